// File: rtl/spi_berry_pkg.sv
// Shared encodings and constants for the address/data bus arbiter.
// Error read data is a wide all-ones constant sliced down to the bus width.
package spi_berry_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned MAX_DATA_WIDTH  = 64;
  localparam logic [MAX_DATA_WIDTH-1:0] ERR_DATA = '1;

endpackage

// File: rtl/ad_bus_pend_slot.sv
// One-deep capture register for single-cycle SPI strobes, with a sticky overrun flag.
// A strobe is latched on the next edge; the slot may be refilled in the cycle it is taken.
module ad_bus_pend_slot #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  take_i,
  input  logic                  clr_ovr_i,
  output logic                  pend_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  overrun_o
);

  logic                  strobe;
  logic                  accept;
  logic                  pend_q, pend_d;
  logic                  we_q, we_d;
  logic                  ovr_q, ovr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  always_comb begin
    strobe  = wr_i | rd_i;
    accept  = strobe & (~pend_q | take_i);
    pend_d  = pend_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovr_d   = ovr_q;
    if (take_i) begin
      pend_d = 1'b0;
    end
    if (accept) begin
      pend_d  = 1'b1;
      we_d    = wr_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end
    if (clr_ovr_i) begin
      ovr_d = 1'b0;
    end
    // A dropped strobe outranks a clear arriving in the same cycle.
    if (strobe & ~accept) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      ovr_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      we_q    <= we_d;
      ovr_q   <= ovr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign pend_o    = pend_q;
  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/ad_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic master between the SPI bus and a req/ack master.
// One cycle in IDLE per grant, registered Wishbone outputs, abort with all-ones data on timeout.
module ad_bus_arbiter
  import spi_berry_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_wr,
  input  logic                  m0_rd,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_busy,
  output logic                  m0_overrun,
  input  logic                  m0_clr_ovr,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_ack_i,
  output logic                  err_timeout
);

  localparam logic [15:0]           TO_LOAD  = 16'(TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = ERR_DATA[DATA_WIDTH-1:0];

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_q, last_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  we_q, we_d;
  logic                  stb_q, stb_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  m1_ack_q, m1_ack_d;
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;

  logic                  pend0, p_we;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [DATA_WIDTH-1:0] p_wdata;
  logic                  idle, cand1, grant0, grant1, expired;

  ad_bus_pend_slot #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_slot (
    .clk      (clk),
    .reset    (reset),
    .wr_i     (m0_wr),
    .rd_i     (m0_rd),
    .addr_i   (m0_addr),
    .wdata_i  (m0_wdata),
    .take_i   (grant0),
    .clr_ovr_i(m0_clr_ovr),
    .pend_o   (pend0),
    .we_o     (p_we),
    .addr_o   (p_addr),
    .wdata_o  (p_wdata),
    .overrun_o(m0_overrun)
  );

  // m1 is masked in its own ack cycle: its req is still high until it sees the ack.
  assign idle    = (state_q == ST_IDLE);
  assign cand1   = m1_req & ~m1_ack_q;
  assign grant0  = idle & pend0 & (~cand1 | (last_q == OWN_M1));
  assign grant1  = idle & cand1 & ~grant0;
  assign expired = ~wb_ack_i & (cnt_q == 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_M0;
      last_q     <= OWN_M1;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      stb_q      <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m1_ack_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      stb_q      <= stb_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m1_ack_q   <= m1_ack_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant0 | grant1) state_d = ST_XFER;
      ST_XFER: if (wb_ack_i | expired) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d    = owner_q;
    last_d     = last_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    stb_d      = stb_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m1_ack_d   = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    if (state_q == ST_IDLE) begin
      if (grant0 | grant1) begin
        owner_d = grant0 ? OWN_M0 : OWN_M1;
        last_d  = grant0 ? OWN_M0 : OWN_M1;
        adr_d   = grant0 ? p_addr : m1_addr;
        dat_d   = grant0 ? p_wdata : m1_wdata;
        we_d    = grant0 ? p_we : m1_we;
        stb_d   = 1'b1;
        cnt_d   = TO_LOAD;
      end
    end else if (wb_ack_i | expired) begin
      stb_d    = 1'b0;
      err_d    = expired;
      m1_ack_d = (owner_q == OWN_M1);
      if (!we_q) begin
        if (owner_q == OWN_M0) m0_rdata_d = expired ? ERR_WORD : wb_dat_i;
        else                   m1_rdata_d = expired ? ERR_WORD : wb_dat_i;
      end
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_comb begin
    m0_busy     = pend0 | ((state_q == ST_XFER) & (owner_q == OWN_M0));
    m0_rdata    = m0_rdata_q;
    m1_rdata    = m1_rdata_q;
    m1_ack      = m1_ack_q;
    wb_adr_o    = adr_q;
    wb_dat_o    = dat_q;
    wb_we_o     = we_q;
    wb_stb_o    = stb_q;
    wb_cyc_o    = stb_q;
    err_timeout = err_q;
  end

endmodule

// File: tb/tb_ad_bus_arbiter.sv
// Directed bench: expected Wishbone cycles and m1 completions are queued by the stimulus and
// popped by independent monitors; timing and flag checks are made inline.
module tb_ad_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic          we;
  } wb_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_addr, m1_addr, wb_adr_o;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, wb_dat_o, wb_dat_i;
  logic          m0_wr, m0_rd, m0_busy, m0_overrun, m0_clr_ovr;
  logic          m1_req, m1_we, m1_ack;
  logic          wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, err_timeout;

  wb_exp_t       wb_q[$];
  logic [DW-1:0] m1_q[$];
  int            tests = 0;
  int            fails = 0;
  int            err_seen = 0;
  int            slave_delay = 0;
  logic [DW-1:0] slave_data = '0;

  always #5 clk = ~clk;

  ad_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr(m0_wr), .m0_rd(m0_rd),
    .m0_rdata(m0_rdata), .m0_busy(m0_busy), .m0_overrun(m0_overrun), .m0_clr_ovr(m0_clr_ovr),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .err_timeout(err_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wb(input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic we);
    wb_exp_t e;
    e.adr = adr; e.dat = dat; e.we = we;
    wb_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_addr = '0; m0_wdata = '0; m0_wr = 1'b0; m0_rd = 1'b0; m0_clr_ovr = 1'b0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic m0_strobe(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_wr = wr; m0_rd = rd; m0_addr = a; m0_wdata = d;
    tick(1);
    m0_wr = 1'b0; m0_rd = 1'b0;
  endtask

  task automatic wait_m1_ack(input int maxc, output int waited);
    waited = 0;
    while (!m1_ack && waited < maxc) begin
      tick(1);
      waited++;
    end
    if (!m1_ack) begin
      tests++; fails++;
      $display("FAIL m1_ack_timeout: no m1_ack within %0d cycles", maxc);
    end
    m1_req = 1'b0;
  endtask

  // Wishbone slave: acks after slave_delay extra stb cycles; negative delay never acks.
  initial begin : slave
    int cnt;
    cnt = 0;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      if (wb_stb_o && wb_cyc_o) cnt++;
      else cnt = 0;
      wb_ack_i = (cnt != 0) && (slave_delay >= 0) && (cnt == slave_delay + 1);
      wb_dat_i = slave_data;
    end
  end

  initial begin : wb_mon
    logic    prev;
    wb_exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_stb_o && !prev) begin
        if (wb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL wb_unexpected: cycle at adr 0x%0h, none required", wb_adr_o);
        end else begin
          e = wb_q.pop_front();
          check("wb_adr", 32'(wb_adr_o), 32'(e.adr));
          check("wb_we", 32'(wb_we_o), 32'(e.we));
          check("wb_cyc", 32'(wb_cyc_o), 32'd1);
          if (e.we) check("wb_dat", 32'(wb_dat_o), 32'(e.dat));
        end
      end
      prev = wb_stb_o;
    end
  end

  initial begin : m1_mon
    logic          prev;
    logic [DW-1:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (err_timeout) err_seen++;
      if (m1_ack) begin
        if (prev) begin
          tests++; fails++;
          $display("FAIL m1_ack_width: ack high two cycles, required one");
        end
        if (m1_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL m1_ack_unexpected: ack with rdata 0x%0h, none required", m1_rdata);
        end else begin
          e = m1_q.pop_front();
          check("m1_rdata", 32'(m1_rdata), 32'(e));
        end
      end
      prev = m1_ack;
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int w, stbcnt;
    do_reset();
    reset = 1'b1;
    tick(1);
    check("reset_wb", {wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o}, 32'd0);
    check("reset_dat", {wb_dat_o, m0_rdata}, 32'd0);
    check("reset_misc", {m1_rdata, m1_ack, err_timeout, m0_busy, m0_overrun}, 32'd0);
    reset = 1'b0;
    tick(1);

    // 1: m0 write, immediate ack
    slave_delay = 0;
    push_wb(16'h0010, 16'hBEEF, 1'b1);
    m0_strobe(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    check("t1_busy_n1", 32'(m0_busy), 32'd1);
    check("t1_stb_n1", 32'(wb_stb_o), 32'd0);
    tick(1);
    check("t1_stb_n2", 32'(wb_stb_o), 32'd1);
    check("t1_busy_n2", 32'(m0_busy), 32'd1);
    tick(1);
    check("t1_stb_n3", 32'(wb_stb_o), 32'd0);
    check("t1_busy_n3", 32'(m0_busy), 32'd0);
    check("t1_ovr", 32'(m0_overrun), 32'd0);

    // 2: m1 read, slave answers after 3 extra cycles
    slave_delay = 3; slave_data = 16'h1234;
    push_wb(16'h0200, 16'h0000, 1'b0);
    m1_q.push_back(16'h1234);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0200;
    wait_m1_ack(20, w);
    check("t2_ack_latency", 32'(w), 32'd5);
    tick(1);
    check("t2_ack_pulse", 32'(m1_ack), 32'd0);
    check("t2_no_regrant", 32'(wb_stb_o), 32'd0);
    tick(1);
    check("t2_no_regrant2", 32'(wb_stb_o), 32'd0);

    // 3: contention at reset exit, then alternation
    do_reset();
    slave_delay = 0; slave_data = 16'hA5A5;
    push_wb(16'h0030, 16'h0000, 1'b0);
    push_wb(16'h0040, 16'h5555, 1'b1);
    m1_q.push_back(16'h0000);
    m0_strobe(1'b0, 1'b1, 16'h0030, 16'h0000);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0040; m1_wdata = 16'h5555;
    wait_m1_ack(20, w);
    check("t3_m1_after_m0", 32'(w), 32'd4);
    check("t3_m0_rdata", 32'(m0_rdata), 32'h0000A5A5);
    tick(1);
    slave_data = 16'h2222;
    push_wb(16'h0050, 16'h1111, 1'b1);
    m0_strobe(1'b1, 1'b0, 16'h0050, 16'h1111);
    tick(2);
    push_wb(16'h0060, 16'h0000, 1'b0);
    push_wb(16'h0070, 16'h3333, 1'b1);
    m1_q.push_back(16'h2222);
    m0_strobe(1'b1, 1'b0, 16'h0070, 16'h3333);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0060;
    wait_m1_ack(20, w);
    check("t3_m1_wins_after_m0", 32'(w), 32'd2);
    tick(2);
    check("t3_idle_busy", 32'(m0_busy), 32'd0);

    // 4: overrun while a long m1 write holds the bus
    slave_delay = 6;
    push_wb(16'h0100, 16'h0A0A, 1'b1);
    push_wb(16'h0111, 16'hC0DE, 1'b1);
    m1_q.push_back(16'h2222);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0100; m1_wdata = 16'h0A0A;
    tick(2);
    m0_wr = 1'b1; m0_addr = 16'h0111; m0_wdata = 16'hC0DE;
    tick(1);
    m0_addr = 16'h0222; m0_wdata = 16'hDEAD;
    check("t4_ovr_before", 32'(m0_overrun), 32'd0);
    tick(1);
    m0_wr = 1'b0;
    check("t4_ovr_set", 32'(m0_overrun), 32'd1);
    check("t4_busy", 32'(m0_busy), 32'd1);
    wait_m1_ack(20, w);
    check("t4_m1_latency", 32'(w), 32'd4);
    slave_delay = 0;
    tick(3);
    check("t4_ovr_sticky", 32'(m0_overrun), 32'd1);
    m0_clr_ovr = 1'b1;
    tick(1);
    m0_clr_ovr = 1'b0;
    check("t4_ovr_clr", 32'(m0_overrun), 32'd0);

    // 5: no slave ack, timeout abort
    slave_delay = -1;
    push_wb(16'h0300, 16'h0000, 1'b0);
    m1_q.push_back(16'hFFFF);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0300;
    stbcnt = 0; w = 0;
    while (!m1_ack && w < 40) begin
      tick(1);
      w++;
      if (wb_stb_o) stbcnt++;
    end
    check("t5_ack_seen", 32'(m1_ack), 32'd1);
    check("t5_err_pulse", 32'(err_timeout), 32'd1);
    m1_req = 1'b0;
    check("t5_stb_cycles", 32'(stbcnt), 32'd8);
    tick(1);
    check("t5_err_one_cycle", 32'(err_timeout), 32'd0);
    check("t5_err_count", 32'(err_seen), 32'd1);

    // 6: reset in the middle of a transfer with m0 pending
    push_wb(16'h0400, 16'h0000, 1'b0);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0400;
    tick(1);
    check("t6_stb", 32'(wb_stb_o), 32'd1);
    m0_strobe(1'b1, 1'b0, 16'h0500, 16'h9999);
    check("t6_pend", 32'(m0_busy), 32'd1);
    reset = 1'b1;
    tick(1);
    check("t6_stbcyc", {wb_stb_o, wb_cyc_o}, 32'd0);
    check("t6_flags", {m0_busy, m1_ack, err_timeout}, 32'd0);
    m1_req = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(12);
    check("t6_quiet", {wb_stb_o, m0_busy}, 32'd0);
    check("t6_no_err", 32'(err_seen), 32'd1);

    check("wbq_drained", 32'(wb_q.size()), 32'd0);
    check("m1q_drained", 32'(m1_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ad_bus_arbiter.md
Name: ad_bus_arbiter

Overview:
- Shares one Wishbone classic master port between two requesters.
- Requester 0 is the SPI-derived address/data bus: single-cycle wr/rd strobes, no stall capability.
- Requester 1 is a req/ack master, e.g. the MCU bridge.
- Captures SPI strobes into a one-deep pending slot, arbitrates round-robin, runs one Wishbone cycle at a time, and returns read data with a bus timeout.

Parameters:
ADDR_WIDTH, 16, address width of both requesters and the Wishbone port
DATA_WIDTH, 16, data width throughout
TIMEOUT, 255, cycles to wait for wb_ack_i before aborting; legal range 1-65535

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
m0_addr  in  ADDR_WIDTH  SPI-side address, valid on the strobe cycle
m0_wdata  in  DATA_WIDTH  SPI-side write data, valid on the strobe cycle
m0_wr  in  1  one-cycle write strobe
m0_rd  in  1  one-cycle read strobe
m0_rdata  out  DATA_WIDTH  data from the last completed m0 read
m0_busy  out  1  m0 request pending or in flight
m0_overrun  out  1  sticky: strobe dropped because the slot was full
m0_clr_ovr  in  1  clears m0_overrun
m1_req  in  1  request level, held until m1_ack
m1_we  in  1  1 = write, 0 = read; stable while m1_req
m1_addr  in  ADDR_WIDTH  stable while m1_req
m1_wdata  in  DATA_WIDTH  stable while m1_req
m1_ack  out  1  one-cycle completion pulse
m1_rdata  out  DATA_WIDTH  read data, valid with m1_ack
wb_adr_o  out  ADDR_WIDTH  Wishbone address
wb_dat_o  out  DATA_WIDTH  Wishbone write data
wb_dat_i  in  DATA_WIDTH  Wishbone read data
wb_we_o  out  1  Wishbone write enable
wb_stb_o  out  1  Wishbone strobe
wb_cyc_o  out  1  Wishbone cycle
wb_ack_i  in  1  Wishbone acknowledge
err_timeout  out  1  one-cycle pulse on an aborted cycle

Behaviour:
- Reset values: all outputs 0, pending slot empty, FSM IDLE, last_owner=1 (m0 wins the first tie).
- Reset mid-cycle: stb/cyc drop at that edge; no ack, no error pulse.
- m0 capture:
  - If m0_wr|m0_rd is high and the slot is empty (or being consumed that same cycle), latch {addr, wdata, we=m0_wr} and set pend0.
  - If the slot is full, drop the strobe and set m0_overrun.
  - m0_wr and m0_rd both high: treat as write.
  - m0_clr_ovr in the same cycle as a new overrun: the set wins.
- m0_busy = pend0 | (state==XFER & owner==0).
- IDLE state:
  - Candidates are pend0, and m1_req with m1_ack low. m1 is not granted in its own ack cycle, which prevents a double issue.
  - One candidate: grant it.
  - Both: grant the requester that is not last_owner.
  - On grant: register wb_adr_o/wb_dat_o/wb_we_o from the winner, assert stb/cyc, record owner and last_owner, clear pend0 if owner=0, load timeout counter = TIMEOUT, go to XFER.
- XFER state:
  - stb/cyc held and outputs stable.
  - On wb_ack_i: deassert stb/cyc at that edge, go to IDLE, and route data:
    - owner 0 read: m0_rdata <= wb_dat_i.
    - owner 1: m1_ack=1 for one cycle; m1_rdata <= wb_dat_i on reads, unchanged on writes.
  - Without ack: decrement the counter. When it reaches 0:
    - Abort: drop stb/cyc and pulse err_timeout.
    - Read data becomes all ones (owner 0: m0_rdata; owner 1: m1_rdata).
    - m1_ack is still pulsed for owner 1.
    - Go to IDLE.
- wb_ack_i outside XFER: ignored.
- Latency:
  - m0 strobe at cycle N: pend0 at N+1, stb high from N+2; ack at N+2 gives m0_rdata at N+3.
  - m1_req rising at N: stb from N+1; ack at N+1 gives m1_ack at N+2.
  - Minimum spacing is 2 cycles per transfer; IDLE takes one cycle.
- The slot refill in the grant cycle means back-to-back m0 strobes every 2 cycles never overrun while the bus acks immediately.

Decomposition:
- Shared package (spi_berry_pkg): FSM state encoding (IDLE, XFER), owner encoding, TIMEOUT default, all-ones error data constant.
- One sub-module, ad_bus_pend_slot: the one-deep m0 capture register with the overrun flag.
- The FSM, round-robin and timeout counter stay in the top module.

Test Plan:
1. m0_wr addr 0x0010 data 0xBEEF, ack one cycle after stb -> wb write 0x0010/0xBEEF with stb from N+2; m0_busy falls after ack; no overrun.
2. m1 read addr 0x0200, slave returns 0x1234 after 3 cycles -> m1_ack single pulse, m1_rdata=0x1234; next grant only if m1_req stays high past the ack cycle.
3. m0_rd and m1_req together at reset exit -> m0 served first, m1 second; repeated contention alternates owners.
4. Two m0 strobes 1 cycle apart while a long m1 cycle holds the bus -> first kept, second dropped, m0_overrun=1 until m0_clr_ovr.
5. No slave ack, TIMEOUT=8, m1 read -> stb held 8 cycles, err_timeout pulse, m1_ack with m1_rdata=0xFFFF.
6. reset asserted mid-XFER -> stb/cyc 0 next edge, pend0 cleared, no m1_ack, no err_timeout.
